// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the write port of the async sample FIFO (wclk domain) among N_REQ
//   producers. A grant lasts for a burst of at most BURST_LEN beats and then
//   rotates round-robin. Accepted beats land in a one-entry output buffer that
//   drives winc/wdata, and no write is issued while the FIFO reports full.
//
//   Optional feature macro: FIFO_WR_ARB_TAG_EN
//     defined     : fifo_wdata = {ob_id, ob_data}, DATA_SIZE+ID_W bits wide
//     not defined : fifo_wdata = ob_data, DATA_SIZE bits wide
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_SIZE = 16,
  parameter int BURST_LEN = 4,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int WDATA_W  = DATA_SIZE + ID_W
`else
  localparam int WDATA_W  = DATA_SIZE
`endif
) (
  input  logic                       wclk,
  input  logic                       wrst_n,
  input  logic                       arb_en,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_SIZE-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_wfull,
  output logic                       fifo_winc,
  output logic [WDATA_W-1:0]         fifo_wdata,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy
);

  // Beat counter only has to reach BURST_LEN-1; keep at least one bit.
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]  owner, owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic                 ob_valid;
  logic [DATA_SIZE-1:0] ob_data;
`ifdef FIFO_WR_ARB_TAG_EN
  logic [ID_W-1:0]      ob_id;
`endif

  logic [DATA_SIZE-1:0] req_word [N_REQ];
  logic                 owner_valid;
  logic                 load_ok;
  logic                 accept;
  logic                 last_beat;
  logic                 burst_exit;
  logic [ID_W-1:0]      owner_inc;
  logic                 rr_found;
  logic [ID_W-1:0]      rr_pick;

  // Unpack the flattened producer data bus into one word per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*DATA_SIZE +: DATA_SIZE];
  end

  // The buffer can take a new beat when it is empty or is draining this cycle.
  assign load_ok     = ~ob_valid | ~fifo_wfull;
  assign owner_valid = req_valid[owner];
  assign accept      = (state == BURST) & owner_valid & load_ok;
  assign last_beat   = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign burst_exit  = (accept & last_beat) | ~owner_valid | ~arb_en;

  // Next round-robin start point after the current owner, wrapping to 0.
  assign owner_inc = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

  // Find the first valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    int cand;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rr_found = 1'b0;
    rr_pick  = rr_ptr;
    cand     = 0;
    // Walk from the farthest candidate down so the nearest one wins last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (req_valid[ID_W'(cand)]) begin
        rr_found = 1'b1;
        rr_pick  = ID_W'(cand);
      end
    end
  end

  // Arbitration FSM next-state logic: grant in IDLE, count and end bursts in BURST.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (arb_en && rr_found) begin
          owner_nxt    = rr_pick;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        if (burst_exit) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = owner_inc;
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration FSM state registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!wrst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // One-entry output buffer: load on an accepted beat, empty once written.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      ob_valid <= 1'b0;
      ob_data  <= '0;
`ifdef FIFO_WR_ARB_TAG_EN
      ob_id    <= '0;
`endif
    end else if (accept) begin
      ob_valid <= 1'b1;
      ob_data  <= req_word[owner];
`ifdef FIFO_WR_ARB_TAG_EN
      ob_id    <= owner;
`endif
    end else if (fifo_winc) begin
      ob_valid <= 1'b0;
    end
  end

  // Only the current owner sees ready, and only while the buffer can load.
  always_comb begin
    req_ready = '0;
    if ((state == BURST) && load_ok) req_ready[owner] = 1'b1;
  end

  // Write strobe is gated combinationally by wfull: the RAM writes on winc
  // regardless of the full flag, so it must never rise while full.
  assign fifo_winc = ob_valid & ~fifo_wfull;

`ifdef FIFO_WR_ARB_TAG_EN
  assign fifo_wdata = {ob_id, ob_data};
`else
  assign fifo_wdata = ob_data;
`endif

  assign grant_id = owner;
  assign busy     = (state == BURST) | ob_valid;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Producers are modelled as data queues; every valid/ready handshake pushes
//   {requester, word} onto a scoreboard and every FIFO write must match its
//   head. Scenario tasks add timing and ordering expectations on top.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DS  = 16;
  localparam int BL  = 4;
  localparam int IDW = 2;
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int WD  = DS + IDW;
`else
  localparam int WD  = DS;
`endif

  logic            wclk = 1'b0;
  logic            wrst_n = 1'b0;
  logic            arb_en = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DS-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_wfull = 1'b0;
  logic            fifo_winc;
  logic [WD-1:0]   fifo_wdata;
  logic [IDW-1:0]  grant_id;
  logic            busy;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DATA_SIZE (DS),
    .BURST_LEN (BL)
  ) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .arb_en     (arb_en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wfull (fifo_wfull),
    .fifo_winc  (fifo_winc),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int          id;
    logic [DS-1:0] data;
  } beat_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            hs_cnt  = 0;
  logic [DS-1:0] prod_q [N][$];
  logic [N-1:0]  mask = '0;
  beat_t         exp_q [$];
  int            wr_cyc [$];
  int            wr_id  [$];

  // Present each producer's head word while its queue is non-empty and enabled.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = mask[i] && (prod_q[i].size() > 0);
      req_data[i*DS +: DS] = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
    end
  endtask

  // Sampled mid-cycle: score FIFO writes, then record this cycle's handshakes.
  task automatic observe();
    beat_t e;
    n_tests++;
    if ($countones(req_ready) > 1) begin
      n_fail++;
      $display("FAIL ready_onehot: req_ready=%b, required at most one bit set", req_ready);
    end
    if (fifo_winc === 1'b1) begin
      n_tests++;
      if (fifo_wfull !== 1'b0) begin
        n_fail++;
        $display("FAIL winc_while_full: winc=1 with wfull=%b, required no write", fifo_wfull);
      end
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: wdata=%h at cycle %0d, required no write", fifo_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        if (fifo_wdata[DS-1:0] !== e.data) begin
          n_fail++;
          $display("FAIL write_data: got %h, required %h (req %0d)", fifo_wdata[DS-1:0], e.data, e.id);
        end
`ifdef FIFO_WR_ARB_TAG_EN
        n_tests++;
        if (fifo_wdata[WD-1:DS] !== IDW'(e.id)) begin
          n_fail++;
          $display("FAIL write_tag: got %0d, required %0d", fifo_wdata[WD-1:DS], e.id);
        end
`endif
        wr_cyc.push_back(cyc);
        wr_id.push_back(e.id);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] === 1'b1) begin
        e.id   = i;
        e.data = prod_q[i][0];
        exp_q.push_back(e);
        void'(prod_q[i].pop_front());
        hs_cnt++;
      end
    end
  endtask

  task automatic to_sample();
    @(negedge wclk);
  endtask

  task automatic finish_cycle();
    observe();
    @(posedge wclk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic step();
    to_sample();
    finish_cycle();
  endtask

  task automatic clear_model();
    mask = '0;
    for (int i = 0; i < N; i++) prod_q[i].delete();
    exp_q.delete();
    wr_cyc.delete();
    wr_id.delete();
    hs_cnt = 0;
  endtask

  task automatic do_reset();
    wrst_n     = 1'b0;
    arb_en     = 1'b0;
    fifo_wfull = 1'b0;
    clear_model();
    drive();
    repeat (2) begin
      @(posedge wclk);
      cyc++;
    end
    #1;
    wrst_n = 1'b1;
    arb_en = 1'b1;
    drive();
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int k = 0;
    while (wr_id.size() < n && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    if (wr_id.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d writes seen, required %0d within %0d cycles", name, wr_id.size(), n, budget);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    while (!(req_valid == '0 && busy === 1'b0 && exp_q.size() == 0) && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    if (!(req_valid == '0 && busy === 1'b0 && exp_q.size() == 0)) begin
      n_fail++;
      $display("FAIL %s_drain: busy=%b pending=%0d after %0d cycles, required idle and empty", name, busy, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    // Power-on reset.
    #1;
    n_tests++;
    if ({fifo_winc, fifo_wdata, req_ready, grant_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: winc=%b wdata=%h ready=%b gid=%0d busy=%b, required all 0", fifo_winc, fifo_wdata, req_ready, grant_id, busy);
    end
    do_reset();
    // Traffic from requester 2 so owner and rr_ptr move away from 0.
    for (int j = 0; j < 6; j++) prod_q[2].push_back(DS'($urandom));
    mask[2] = 1'b1;
    drive();
    repeat (4) step();
    n_tests++;
    if (grant_id !== 2'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_grant: gid=%0d busy=%b, required 2 and 1", grant_id, busy);
    end
    #2;
    wrst_n = 1'b0;
    #1;
    n_tests++;
    if ({fifo_winc, fifo_wdata, req_ready, grant_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: winc=%b wdata=%h ready=%b gid=%0d busy=%b, required all 0", fifo_winc, fifo_wdata, req_ready, grant_id, busy);
    end
    clear_model();
    @(posedge wclk);
    cyc++;
    #1;
    wrst_n = 1'b1;
    prod_q[0].push_back(16'hA0A0);
    prod_q[0].push_back(16'hA1A1);
    prod_q[3].push_back(16'hD0D0);
    prod_q[3].push_back(16'hD1D1);
    mask = 4'b1001;
    drive();
    wait_writes(1, 10, "post_reset");
    n_tests++;
    if (wr_id.size() > 0 && wr_id[0] != 0) begin
      n_fail++;
      $display("FAIL post_reset_owner: first grant to %0d, required 0", wr_id[0]);
    end
    drain(60, "post_reset");
  endtask

  task automatic test_single_req();
    int c0;
    do_reset();
    c0 = cyc;
    prod_q[0].push_back(16'h1111);
    prod_q[0].push_back(16'h2222);
    prod_q[0].push_back(16'h3333);
    mask[0] = 1'b1;
    drive();
    wait_writes(3, 20, "single");
    drain(20, "single");
    n_tests++;
    if (wr_id.size() != 3 || hs_cnt != 3) begin
      n_fail++;
      $display("FAIL single_count: writes=%0d beats=%0d, required 3 and 3", wr_id.size(), hs_cnt);
    end
    if (wr_cyc.size() >= 3) begin
      n_tests++;
      if (wr_cyc[0] - c0 != 2) begin
        n_fail++;
        $display("FAIL single_latency: first winc %0d cycles after valid, required 2", wr_cyc[0] - c0);
      end
      n_tests++;
      if (wr_cyc[1] != wr_cyc[0] + 1 || wr_cyc[2] != wr_cyc[0] + 2) begin
        n_fail++;
        $display("FAIL single_b2b: write cycles %0d,%0d,%0d, required consecutive", wr_cyc[0], wr_cyc[1], wr_cyc[2]);
      end
    end
  endtask

  task automatic test_round_robin();
    int c0;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    c0 = cyc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) prod_q[i].push_back(DS'($urandom));
    mask = '1;
    drive();
    wait_writes(20, 100, "rr");
    mask = '0;
    drive();
    drain(40, "rr");
    if (wr_id.size() >= 20) begin
      n_tests++;
      if (wr_cyc[0] - c0 != 2) begin
        n_fail++;
        $display("FAIL rr_latency: first winc %0d cycles after valid, required 2", wr_cyc[0] - c0);
      end
      for (int k = 0; k < 20; k++) begin
        n_tests++;
        if (wr_id[k] != order[k/BL]) begin
          n_fail++;
          $display("FAIL rr_owner: write %0d from req %0d, required %0d", k, wr_id[k], order[k/BL]);
        end
      end
      for (int k = 1; k < 20; k++) begin
        n_tests++;
        if (wr_cyc[k] - wr_cyc[k-1] != ((k % BL == 0) ? 2 : 1)) begin
          n_fail++;
          $display("FAIL rr_spacing: write %0d gap %0d, required %0d", k, wr_cyc[k] - wr_cyc[k-1], (k % BL == 0) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_wfull();
    logic [DS-1:0] held;
    do_reset();
    for (int j = 0; j < 6; j++) prod_q[0].push_back(DS'($urandom));
    mask[0] = 1'b1;
    drive();
    wait_writes(1, 10, "wfull");
    held = (exp_q.size() > 0) ? exp_q[0].data : '0;
    fifo_wfull = 1'b1;
    for (int j = 0; j < 5; j++) begin
      to_sample();
      n_tests++;
      if (fifo_winc !== 1'b0 || req_ready !== '0 || fifo_wdata[DS-1:0] !== held) begin
        n_fail++;
        $display("FAIL wfull_hold: cycle %0d winc=%b ready=%b wdata=%h, required 0, 0, %h", j, fifo_winc, req_ready, fifo_wdata[DS-1:0], held);
      end
      finish_cycle();
    end
    fifo_wfull = 1'b0;
    drain(40, "wfull");
    n_tests++;
    if (hs_cnt != 6 || wr_id.size() != 6) begin
      n_fail++;
      $display("FAIL wfull_count: beats=%0d writes=%0d, required 6 and 6", hs_cnt, wr_id.size());
    end
  endtask

  task automatic test_early_end();
    int exp1 [5] = '{1, 1, 2, 2, 2};
    int exp2 [3] = '{0, 0, 1};
    do_reset();
    for (int j = 0; j < 2; j++) prod_q[1].push_back(DS'($urandom));
    for (int j = 0; j < 3; j++) prod_q[2].push_back(DS'($urandom));
    mask = 4'b0110;
    drive();
    drain(60, "early");
    n_tests++;
    if (wr_id.size() != 5) begin
      n_fail++;
      $display("FAIL early_count: %0d writes, required 5", wr_id.size());
    end
    for (int k = 0; k < 5 && k < wr_id.size(); k++) begin
      n_tests++;
      if (wr_id[k] != exp1[k]) begin
        n_fail++;
        $display("FAIL early_owner: write %0d from req %0d, required %0d", k, wr_id[k], exp1[k]);
      end
    end
    n_tests++;
    if (grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL early_last_owner: gid=%0d, required 2", grant_id);
    end
    // rr_ptr now points past requester 2; requester 3 idle, so search wraps to 0.
    for (int j = 0; j < 2; j++) prod_q[0].push_back(DS'($urandom));
    prod_q[1].push_back(DS'($urandom));
    mask = 4'b0011;
    drive();
    drain(60, "wrap");
    n_tests++;
    if (wr_id.size() != 8) begin
      n_fail++;
      $display("FAIL wrap_count: %0d writes, required 8", wr_id.size());
    end
    for (int k = 0; k < 3 && k + 5 < wr_id.size(); k++) begin
      n_tests++;
      if (wr_id[k+5] != exp2[k]) begin
        n_fail++;
        $display("FAIL wrap_owner: write %0d from req %0d, required %0d", k + 5, wr_id[k+5], exp2[k]);
      end
    end
    n_tests++;
    if (grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_last_owner: gid=%0d, required 1", grant_id);
    end
  endtask

  task automatic test_arb_en();
    do_reset();
    for (int j = 0; j < 8; j++) prod_q[0].push_back(DS'($urandom));
    mask[0] = 1'b1;
    drive();
    wait_writes(1, 10, "arb_en");
    arb_en = 1'b0;
    for (int j = 0; j < 6; j++) begin
      to_sample();
      n_tests++;
      if (req_ready !== ((j == 0) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL arb_en_ready: cycle %0d ready=%b, required %b", j, req_ready, (j == 0) ? 4'b0001 : 4'b0000);
      end
      finish_cycle();
    end
    n_tests++;
    if (hs_cnt != 3 || wr_id.size() != 3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_en_stop: beats=%0d writes=%0d busy=%b, required 3, 3, 0", hs_cnt, wr_id.size(), busy);
    end
    arb_en = 1'b1;
    drain(60, "arb_en");
    n_tests++;
    if (hs_cnt != 8 || wr_id.size() != 8) begin
      n_fail++;
      $display("FAIL arb_en_resume: beats=%0d writes=%0d, required 8 and 8", hs_cnt, wr_id.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 40; j++) prod_q[i].push_back(DS'($urandom));
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) mask[i] = ($urandom_range(0, 3) != 0);
      fifo_wfull = ($urandom_range(0, 9) < 3);
      arb_en     = ($urandom_range(0, 19) != 0);
      drive();
      step();
    end
    fifo_wfull = 1'b0;
    arb_en     = 1'b1;
    mask       = '1;
    drive();
    drain(2000, "random");
    n_tests++;
    if (hs_cnt != 4 * 40 || wr_id.size() != 4 * 40) begin
      n_fail++;
      $display("FAIL random_count: beats=%0d writes=%0d, required 160 and 160", hs_cnt, wr_id.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_wfull();
    test_early_end();
    test_arb_en();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
